// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions used by the decode, ID/EX and EX stages:
// default datapath widths and the 4-bit ALU operation encodings.
package id_ex_stage_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int RA_W_DEF   = 5;
   localparam int ALU_OP_W   = 4;

   typedef enum logic [ALU_OP_W-1:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_NOR  = 4'd5,
      ALU_SLT  = 4'd6,
      ALU_SLTU = 4'd7,
      ALU_SLL  = 4'd8,
      ALU_SRL  = 4'd9,
      ALU_SRA  = 4'd10,
      ALU_LUI  = 4'd11
   } alu_op_e;

   // A bubble must present op code zero to the EX stage.
   localparam logic [ALU_OP_W-1:0] ALU_OP_BUBBLE = ALU_ADD;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decode-side fields, registered EX-side fields,
// branch flush and the load-use stall feedback.
interface id_ex_stage_if
   import id_ex_stage_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int RA_W   = RA_W_DEF,
   parameter int CNT_W  = 16
);
   logic                       id_valid;
   logic        [RA_W-1:0]     id_rs, id_rt, id_rd;
   logic                       id_uses_rt;
   logic signed [DATA_W-1:0]   id_a, id_b, id_imm;
   logic                       id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_reg_dst;
   logic        [ALU_OP_W-1:0] id_alu_op;
   logic                       flush;

   logic                       ex_valid;
   logic        [RA_W-1:0]     ex_rs, ex_rt, ex_rd, ex_wr_addr;
   logic                       ex_uses_rt;
   logic signed [DATA_W-1:0]   ex_a, ex_b, ex_imm;
   logic                       ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_dst;
   logic        [ALU_OP_W-1:0] ex_alu_op;

   logic                       stall;
   logic        [CNT_W-1:0]    stall_count;

   modport master (
      output id_valid, id_rs, id_rt, id_rd, id_uses_rt, id_a, id_b, id_imm,
             id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_reg_dst,
             id_alu_op, flush,
      input  ex_valid, ex_rs, ex_rt, ex_rd, ex_wr_addr, ex_uses_rt, ex_a, ex_b, ex_imm,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_dst,
             ex_alu_op, stall, stall_count
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_rd, id_uses_rt, id_a, id_b, id_imm,
             id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_reg_dst,
             id_alu_op, flush,
      output ex_valid, ex_rs, ex_rt, ex_rd, ex_wr_addr, ex_uses_rt, ex_a, ex_b, ex_imm,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_dst,
             ex_alu_op, stall, stall_count
   );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection between the decode-stage instruction and a load
// held in ID/EX. Purely combinational.
module hazard_detect
   import id_ex_stage_pkg::*;
#(
   parameter int RA_W = RA_W_DEF
) (
   input  logic            id_valid,
   input  logic [RA_W-1:0] id_rs,
   input  logic [RA_W-1:0] id_rt,
   input  logic            id_uses_rt,
   input  logic            ex_valid,
   input  logic            ex_mem_read,
   input  logic [RA_W-1:0] ex_wr_addr,
   input  logic            flush,
   output logic            hazard,
   output logic            stall
);

   logic rs_match;
   logic rt_match;

   assign rs_match = (ex_wr_addr == id_rs);
   assign rt_match = id_uses_rt & (ex_wr_addr == id_rt);

   // Register 0 is hard-wired, so a load targeting it never blocks a reader.
   assign hazard = id_valid & ex_valid & ex_mem_read & (ex_wr_addr != '0)
                 & (rs_match | rt_match);

   // A killed instruction has no consumer, so flush suppresses the stall.
   assign stall = hazard & ~flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall insertion, branch-flush
// bubbles and a saturating stall-cycle counter.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int RA_W   = RA_W_DEF,
   parameter int CNT_W  = 16
) (
   input logic          clk,
   input logic          rst_n,
   id_ex_stage_if.slave bus
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
   endfunction

   logic hazard;
   logic stall;
   logic bubble;

   hazard_detect #(.RA_W(RA_W)) u_hazard (
      .id_valid    (bus.id_valid),
      .id_rs       (bus.id_rs),
      .id_rt       (bus.id_rt),
      .id_uses_rt  (bus.id_uses_rt),
      .ex_valid    (bus.ex_valid),
      .ex_mem_read (bus.ex_mem_read),
      .ex_wr_addr  (bus.ex_wr_addr),
      .flush       (bus.flush),
      .hazard      (hazard),
      .stall       (stall)
   );

   assign bus.stall = stall;
   // flush | stall reduces to flush | hazard.
   assign bubble = bus.flush | hazard | ~bus.id_valid;

   logic                       nxt_valid;
   logic        [RA_W-1:0]     nxt_rs, nxt_rt, nxt_rd, nxt_wr_addr;
   logic                       nxt_uses_rt;
   logic signed [DATA_W-1:0]   nxt_a, nxt_b, nxt_imm;
   logic                       nxt_reg_write, nxt_mem_read, nxt_mem_write, nxt_alu_src, nxt_reg_dst;
   logic        [ALU_OP_W-1:0] nxt_alu_op;

   always_comb begin
      nxt_valid     = 1'b0;
      nxt_rs        = '0;
      nxt_rt        = '0;
      nxt_rd        = '0;
      nxt_wr_addr   = '0;
      nxt_uses_rt   = 1'b0;
      nxt_a         = '0;
      nxt_b         = '0;
      nxt_imm       = '0;
      nxt_reg_write = 1'b0;
      nxt_mem_read  = 1'b0;
      nxt_mem_write = 1'b0;
      nxt_alu_src   = 1'b0;
      nxt_reg_dst   = 1'b0;
      nxt_alu_op    = ALU_OP_BUBBLE;
      if (!bubble) begin
         nxt_valid     = 1'b1;
         nxt_rs        = bus.id_rs;
         nxt_rt        = bus.id_rt;
         nxt_rd        = bus.id_rd;
         nxt_wr_addr   = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
         nxt_uses_rt   = bus.id_uses_rt;
         nxt_a         = bus.id_a;
         nxt_b         = bus.id_b;
         nxt_imm       = bus.id_imm;
         nxt_reg_write = bus.id_reg_write;
         nxt_mem_read  = bus.id_mem_read;
         nxt_mem_write = bus.id_mem_write;
         nxt_alu_src   = bus.id_alu_src;
         nxt_reg_dst   = bus.id_reg_dst;
         nxt_alu_op    = bus.id_alu_op;
      end
   end

   // ---- ID -> EX register boundary ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.ex_valid     <= 1'b0;
         bus.ex_rs        <= '0;
         bus.ex_rt        <= '0;
         bus.ex_rd        <= '0;
         bus.ex_wr_addr   <= '0;
         bus.ex_uses_rt   <= 1'b0;
         bus.ex_a         <= '0;
         bus.ex_b         <= '0;
         bus.ex_imm       <= '0;
         bus.ex_reg_write <= 1'b0;
         bus.ex_mem_read  <= 1'b0;
         bus.ex_mem_write <= 1'b0;
         bus.ex_alu_src   <= 1'b0;
         bus.ex_reg_dst   <= 1'b0;
         bus.ex_alu_op    <= '0;
         bus.stall_count  <= '0;
      end else begin
         bus.ex_valid     <= nxt_valid;
         bus.ex_rs        <= nxt_rs;
         bus.ex_rt        <= nxt_rt;
         bus.ex_rd        <= nxt_rd;
         bus.ex_wr_addr   <= nxt_wr_addr;
         bus.ex_uses_rt   <= nxt_uses_rt;
         bus.ex_a         <= nxt_a;
         bus.ex_b         <= nxt_b;
         bus.ex_imm       <= nxt_imm;
         bus.ex_reg_write <= nxt_reg_write;
         bus.ex_mem_read  <= nxt_mem_read;
         bus.ex_mem_write <= nxt_mem_write;
         bus.ex_alu_src   <= nxt_alu_src;
         bus.ex_reg_dst   <= nxt_reg_dst;
         bus.ex_alu_op    <= nxt_alu_op;
         if (stall) begin
            bus.stall_count <= sat_inc(bus.stall_count);
         end
      end
   end

endmodule
